// File: rtl/adder_arbiter_if.sv
// Request/response bundle for adder_arbiter.
// master: operand producers and result consumer. slave: the arbiter.
interface adder_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 64
) ();
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
  logic [ID_W-1:0]       rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
  );
endinterface

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one WIDTH-bit adder between NREQ
// requesters, with a single registered response slot (valid/ready).
// Optional per-requester saturating grant counters when ADDER_ARB_STATS_EN
// is defined (adds stats_clr / grant_cnt ports).
module adder_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  adder_arbiter_if.slave        bus,
  output logic                  busy
`ifdef ADDER_ARB_STATS_EN
  ,
  input  logic                  stats_clr,
  output logic [NREQ*CNT_W-1:0] grant_cnt
`endif
);

  localparam int ID_W = $clog2(NREQ);

  // Response slot and priority pointer.
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_sum_q,   rsp_sum_d;
  logic             rsp_cout_q,  rsp_cout_d;
  logic [ID_W-1:0]  rsp_id_q,    rsp_id_d;
  logic [ID_W-1:0]  ptr_q,       ptr_d;

  // Arbitration results.
  logic             accept;
  logic             cand_found;
  logic [ID_W-1:0]  cand_idx;
  logic             grant;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH:0]   sum_full;

  assign accept = !rsp_valid_q || bus.rsp_ready;

  // Round-robin search: first valid requester at or after ptr, with wrap.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    int idx;
    cand_found = 1'b0;
    cand_idx   = '0;
    idx        = 0;
    // Walk offsets from far to near so the nearest valid requester wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (bus.req_valid[idx]) begin
        cand_found = 1'b1;
        cand_idx   = ID_W'(idx);
      end
    end
  end

  assign grant         = cand_found && accept;
  assign bus.req_ready = grant ? (NREQ'(1) << cand_idx) : '0;

  // Shared adder: operands of the candidate, zero-extended so bit WIDTH is carry.
  always_comb begin
    a_sel    = bus.req_a[int'(cand_idx)*WIDTH +: WIDTH];
    b_sel    = bus.req_b[int'(cand_idx)*WIDTH +: WIDTH];
    sum_full = {1'b0, a_sel} + {1'b0, b_sel};
  end

  // Next slot contents and pointer: load on a grant, drain on rsp handshake.
  always_comb begin
    rsp_valid_d = grant || (rsp_valid_q && !bus.rsp_ready);
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_id_d    = rsp_id_q;
    ptr_d       = ptr_q;
    if (grant) begin
      rsp_sum_d  = sum_full[WIDTH-1:0];
      rsp_cout_d = sum_full[WIDTH];
      rsp_id_d   = cand_idx;
      ptr_d      = (cand_idx == ID_W'(NREQ - 1)) ? '0 : cand_idx + 1'b1;
    end
  end

  // Slot and pointer registers.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_id_q    <= rsp_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = rsp_valid_q || (|bus.req_valid);

`ifdef ADDER_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [NREQ];
  logic [CNT_W-1:0] cnt_d [NREQ];

  // Counter update: clear beats a same-cycle grant; increments saturate.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stats_clr) begin
        cnt_d[i] = '0;
      end else if (grant && (cand_idx == ID_W'(i)) && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt_out
    assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`endif

endmodule
